// File: rtl/ball_pixel_gen.sv
// Draws a square ball bouncing inside the visible area on a solid background.
// The ball moves once per frame during vertical blanking, so there is no tearing.
module ball_pixel_gen #(
    parameter int         SCR_W     = 640,
    parameter int         SCR_H     = 480,
    parameter int         BALL_SIZE = 8,
    parameter int         BALL_V    = 2,
    parameter logic [2:0] BG_COLOR  = 3'b001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic       utick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       pause,
    output logic [2:0] rgb,
    output logic       frame_tick,
    output logic       bounce
);

    localparam logic [9:0]  X_MAX  = 10'(SCR_W - BALL_SIZE);
    localparam logic [9:0]  Y_MAX  = 10'(SCR_H - BALL_SIZE);
    localparam logic [9:0]  X_INIT = 10'((SCR_W - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_INIT = 10'((SCR_H - BALL_SIZE) / 2);
    localparam logic [9:0]  VEL    = 10'(BALL_V);
    localparam logic [10:0] VEL_W  = 11'(BALL_V);
    localparam logic [10:0] SIZE_W = 11'(BALL_SIZE);
    localparam logic [9:0]  LAST_Y = 10'(SCR_H);

    logic [9:0] x_reg, y_reg;
    logic       dx, dy;
    logic [2:0] bounce_cnt;

    logic       pre_tick;
    logic       move;
    logic       hit_x, hit_y;
    logic [9:0] x_nxt, y_nxt;
    logic [2:0] ball_color;
    logic       ball_on;

    assign pre_tick = utick && (pixel_x == 10'd0) && (pixel_y == LAST_Y);
    assign move     = frame_tick && !pause;

    // Per-axis motion: clamp to the wall and flip direction on a hit.
    always_comb begin
        hit_x = 1'b0;
        x_nxt = x_reg;
        if (dx) begin
            hit_x = ({1'b0, x_reg} + VEL_W) >= {1'b0, X_MAX};
            x_nxt = hit_x ? X_MAX : x_reg + VEL;
        end else begin
            hit_x = x_reg <= VEL;
            x_nxt = hit_x ? 10'd0 : x_reg - VEL;
        end
    end

    always_comb begin
        hit_y = 1'b0;
        y_nxt = y_reg;
        if (dy) begin
            hit_y = ({1'b0, y_reg} + VEL_W) >= {1'b0, Y_MAX};
            y_nxt = hit_y ? Y_MAX : y_reg + VEL;
        end else begin
            hit_y = y_reg <= VEL;
            y_nxt = hit_y ? 10'd0 : y_reg - VEL;
        end
    end

    always_comb begin
        ball_color = (bounce_cnt == 3'd0) ? 3'b111 : bounce_cnt;
        ball_on = ({1'b0, pixel_x} >= {1'b0, x_reg})
               && ({1'b0, pixel_x} <  ({1'b0, x_reg} + SIZE_W))
               && ({1'b0, pixel_y} >= {1'b0, y_reg})
               && ({1'b0, pixel_y} <  ({1'b0, y_reg} + SIZE_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg      <= X_INIT;
            y_reg      <= Y_INIT;
            dx         <= 1'b1;
            dy         <= 1'b1;
            bounce_cnt <= 3'd0;
            frame_tick <= 1'b0;
            bounce     <= 1'b0;
        end else begin
            frame_tick <= pre_tick;
            bounce     <= move && (hit_x || hit_y);
            if (move) begin
                x_reg <= x_nxt;
                y_reg <= y_nxt;
                if (hit_x) dx <= ~dx;
                if (hit_y) dy <= ~dy;
                // A corner hit counts as a single bounce.
                if (hit_x || hit_y) bounce_cnt <= bounce_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= 3'b000;
        end else if (utick) begin
            if (!video_on)
                rgb <= 3'b000;
            else if (ball_on)
                rgb <= ball_color;
            else
                rgb <= BG_COLOR;
        end
    end

endmodule
